// File: rtl/rob_wb_commit.sv
// rob_wb_commit: ROB completion/commit table at the receiving end of the EX->ROB
// writeback channels.
//
// Dispatch allocates entries in order at the tail. The alu, forwarder and jump
// channels mark entries done by tag, in any order. The head entry retires in
// program order, at most one per cycle. A jump whose resolved target differs
// from ori_pc+4 raises a one-cycle redirect and flushes the whole table.
//
// Configuration macro ROB_BYPASS_EN:
//   defined   - a writeback to the head in cycle N is visible on o_commit_* in N+1.
//   undefined - the writeback sets done at edge N; the commit is visible in N+2.
//
// Ports:
//   i_clk, i_rst          clock; synchronous active-low reset
//   i_alloc_valid/dest/is_jump, o_alloc_ready, o_alloc_tag   dispatch allocation
//   i_alu_target/result, i_fwd_target/result                 value writebacks
//   i_jmp_target/ori_pc/next_pc                              jump writeback
//   o_commit_valid/tag/dest/value                            registered retirement
//   o_redirect_valid/pc                                      registered mispredict redirect
//   o_count                                                  live entries (0..ENTRIES)
module rob_wb_commit #(
   parameter int unsigned ENTRIES = 8,
   parameter int unsigned TAG_W   = 4,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned REG_W   = 5
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_alloc_valid,
   input  logic [REG_W-1:0]  i_alloc_dest,
   input  logic              i_alloc_is_jump,
   output logic              o_alloc_ready,
   output logic [TAG_W-1:0]  o_alloc_tag,
   input  logic [TAG_W-1:0]  i_alu_target,
   input  logic [DATA_W-1:0] i_alu_result,
   input  logic [TAG_W-1:0]  i_fwd_target,
   input  logic [DATA_W-1:0] i_fwd_result,
   input  logic [TAG_W-1:0]  i_jmp_target,
   input  logic [DATA_W-1:0] i_jmp_ori_pc,
   input  logic [DATA_W-1:0] i_jmp_next_pc,
   output logic              o_commit_valid,
   output logic [TAG_W-1:0]  o_commit_tag,
   output logic [REG_W-1:0]  o_commit_dest,
   output logic [DATA_W-1:0] o_commit_value,
   output logic              o_redirect_valid,
   output logic [DATA_W-1:0] o_redirect_pc,
   output logic [TAG_W-1:0]  o_count
);

   localparam int unsigned      IDX_W       = $clog2(ENTRIES);
   localparam logic [TAG_W-1:0] TAG_INVALID = '1;
   localparam logic [TAG_W-1:0] TAG_LIMIT   = TAG_W'(ENTRIES);

   // Entry state
   logic [ENTRIES-1:0] r_valid;
   logic [ENTRIES-1:0] r_done;
   logic [ENTRIES-1:0] r_is_jump;
   logic [ENTRIES-1:0] r_mispred;
   logic [REG_W-1:0]   r_dest    [ENTRIES];
   logic [DATA_W-1:0]  r_value   [ENTRIES];
   logic [DATA_W-1:0]  r_next_pc [ENTRIES];
   logic [IDX_W-1:0]   r_head;
   logic [IDX_W-1:0]   r_tail;
   logic [TAG_W-1:0]   r_count;

   // Registered outputs
   logic               r_commit_valid;
   logic [TAG_W-1:0]   r_commit_tag;
   logic [REG_W-1:0]   r_commit_dest;
   logic [DATA_W-1:0]  r_commit_value;
   logic               r_redirect_valid;
   logic [DATA_W-1:0]  r_redirect_pc;

   // Channel decode
   logic [IDX_W-1:0]   w_alu_idx;
   logic [IDX_W-1:0]   w_fwd_idx;
   logic [IDX_W-1:0]   w_jmp_idx;
   logic               w_alu_hit;
   logic               w_fwd_hit;
   logic               w_jmp_hit;
   logic [DATA_W-1:0]  w_jmp_link;
   logic               w_jmp_mis;

   // Per-entry winning writeback
   logic [ENTRIES-1:0] w_wr_en;
   logic [ENTRIES-1:0] w_wr_mis;
   logic [DATA_W-1:0]  w_wr_value [ENTRIES];
   logic [DATA_W-1:0]  w_wr_npc   [ENTRIES];

   // Head view and control
   logic               w_head_done;
   logic [DATA_W-1:0]  w_head_value;
   logic [DATA_W-1:0]  w_head_npc;
   logic               w_head_mis;
   logic               w_commit;
   logic               w_flush;
   logic               w_alloc_ready;
   logic               w_alloc;

   assign w_alu_idx = i_alu_target[IDX_W-1:0];
   assign w_fwd_idx = i_fwd_target[IDX_W-1:0];
   assign w_jmp_idx = i_jmp_target[IDX_W-1:0];

   // Writes to out-of-range, invalid-tag or unallocated entries are dropped silently.
   assign w_alu_hit = (i_alu_target != TAG_INVALID) && (i_alu_target < TAG_LIMIT) &&
                      r_valid[w_alu_idx];
   assign w_fwd_hit = (i_fwd_target != TAG_INVALID) && (i_fwd_target < TAG_LIMIT) &&
                      r_valid[w_fwd_idx];
   assign w_jmp_hit = (i_jmp_target != TAG_INVALID) && (i_jmp_target < TAG_LIMIT) &&
                      r_valid[w_jmp_idx];

   assign w_jmp_link = i_jmp_ori_pc + DATA_W'(4);
   assign w_jmp_mis  = (i_jmp_next_pc != w_jmp_link);

   // Same-tag collisions resolve jmp > alu > fwd.
   always_comb begin
      w_wr_en  = '0;
      w_wr_mis = '0;
      for (int e = 0; e < ENTRIES; e++) begin
         w_wr_value[e] = '0;
         w_wr_npc[e]   = '0;
         if (w_jmp_hit && (w_jmp_idx == IDX_W'(e))) begin
            w_wr_en[e]    = 1'b1;
            w_wr_mis[e]   = w_jmp_mis;
            w_wr_value[e] = w_jmp_link;
            w_wr_npc[e]   = i_jmp_next_pc;
         end else if (w_alu_hit && (w_alu_idx == IDX_W'(e))) begin
            w_wr_en[e]    = 1'b1;
            w_wr_value[e] = i_alu_result;
         end else if (w_fwd_hit && (w_fwd_idx == IDX_W'(e))) begin
            w_wr_en[e]    = 1'b1;
            w_wr_value[e] = i_fwd_result;
         end
      end
   end

`ifdef ROB_BYPASS_EN
   // This cycle's winning writeback to the head counts as done and supplies the value.
   assign w_head_done  = r_done[r_head] | w_wr_en[r_head];
   assign w_head_value = w_wr_en[r_head] ? w_wr_value[r_head] : r_value[r_head];
   assign w_head_npc   = w_wr_en[r_head] ? w_wr_npc[r_head]   : r_next_pc[r_head];
   assign w_head_mis   = w_wr_en[r_head] ? w_wr_mis[r_head]   : r_mispred[r_head];
`else
   assign w_head_done  = r_done[r_head];
   assign w_head_value = r_value[r_head];
   assign w_head_npc   = r_next_pc[r_head];
   assign w_head_mis   = r_mispred[r_head];
`endif

   assign w_commit      = r_valid[r_head] && w_head_done;
   assign w_flush       = w_commit && r_is_jump[r_head] && w_head_mis;
   // Deliberately ignores a same-cycle commit: a full table never allocates.
   assign w_alloc_ready = (r_count < TAG_LIMIT) && !r_redirect_valid;
   assign w_alloc       = i_alloc_valid && w_alloc_ready;

   always_ff @(posedge i_clk) begin
      if (!i_rst) begin
         r_valid          <= '0;
         r_done           <= '0;
         r_is_jump        <= '0;
         r_mispred        <= '0;
         for (int e = 0; e < ENTRIES; e++) begin
            r_dest[e]    <= '0;
            r_value[e]   <= '0;
            r_next_pc[e] <= '0;
         end
         r_head           <= '0;
         r_tail           <= '0;
         r_count          <= '0;
         r_commit_valid   <= 1'b0;
         r_commit_tag     <= TAG_INVALID;
         r_commit_dest    <= '0;
         r_commit_value   <= '0;
         r_redirect_valid <= 1'b0;
         r_redirect_pc    <= '0;
      end else begin
         r_commit_valid   <= w_commit;
         r_redirect_valid <= w_flush;
         if (w_commit) begin
            r_commit_tag   <= TAG_W'(r_head);
            r_commit_dest  <= r_dest[r_head];
            r_commit_value <= w_head_value;
         end
         if (w_flush) begin
            // Same-edge writebacks and allocation are discarded with the flush.
            r_redirect_pc <= w_head_npc;
            r_valid       <= '0;
            r_done        <= '0;
            r_head        <= '0;
            r_tail        <= '0;
            r_count       <= '0;
         end else begin
            for (int e = 0; e < ENTRIES; e++) begin
               if (w_wr_en[e]) begin
                  r_done[e]    <= 1'b1;
                  r_mispred[e] <= w_wr_mis[e];
                  r_value[e]   <= w_wr_value[e];
                  r_next_pc[e] <= w_wr_npc[e];
               end
            end
            // Retirement clears the head after any same-cycle write to it.
            if (w_commit) begin
               r_valid[r_head] <= 1'b0;
               r_done[r_head]  <= 1'b0;
               r_head          <= r_head + IDX_W'(1);
            end
            // Tail never aliases the head here: full blocks alloc, empty blocks commit.
            if (w_alloc) begin
               r_valid[r_tail]   <= 1'b1;
               r_done[r_tail]    <= 1'b0;
               r_mispred[r_tail] <= 1'b0;
               r_is_jump[r_tail] <= i_alloc_is_jump;
               r_dest[r_tail]    <= i_alloc_dest;
               r_tail            <= r_tail + IDX_W'(1);
            end
            r_count <= r_count + TAG_W'(w_alloc) - TAG_W'(w_commit);
         end
      end
   end

   assign o_alloc_ready    = w_alloc_ready;
   assign o_alloc_tag      = TAG_W'(r_tail);
   assign o_commit_valid   = r_commit_valid;
   assign o_commit_tag     = r_commit_tag;
   assign o_commit_dest    = r_commit_dest;
   assign o_commit_value   = r_commit_value;
   assign o_redirect_valid = r_redirect_valid;
   assign o_redirect_pc    = r_redirect_pc;
   assign o_count          = r_count;

endmodule

// File: tb/tb_rob_wb_commit.sv
// Self-checking bench for rob_wb_commit: directed scenarios with literal
// expectations plus a randomized run, all checked every cycle against a
// queue-based model of the table.
module tb_rob_wb_commit;

   localparam int ENTRIES = 8;
`ifdef ROB_BYPASS_EN
   localparam int LAT = 1;
`else
   localparam int LAT = 2;
`endif

   logic        clk;
   logic        rst;
   logic        alloc_valid;
   logic [4:0]  alloc_dest;
   logic        alloc_is_jump;
   logic        o_alloc_ready;
   logic [3:0]  o_alloc_tag;
   logic [3:0]  alu_target;
   logic [31:0] alu_result;
   logic [3:0]  fwd_target;
   logic [31:0] fwd_result;
   logic [3:0]  jmp_target;
   logic [31:0] jmp_ori_pc;
   logic [31:0] jmp_next_pc;
   logic        o_commit_valid;
   logic [3:0]  o_commit_tag;
   logic [4:0]  o_commit_dest;
   logic [31:0] o_commit_value;
   logic        o_redirect_valid;
   logic [31:0] o_redirect_pc;
   logic [3:0]  o_count;

   rob_wb_commit dut (
      .i_clk           (clk),
      .i_rst           (rst),
      .i_alloc_valid   (alloc_valid),
      .i_alloc_dest    (alloc_dest),
      .i_alloc_is_jump (alloc_is_jump),
      .o_alloc_ready   (o_alloc_ready),
      .o_alloc_tag     (o_alloc_tag),
      .i_alu_target    (alu_target),
      .i_alu_result    (alu_result),
      .i_fwd_target    (fwd_target),
      .i_fwd_result    (fwd_result),
      .i_jmp_target    (jmp_target),
      .i_jmp_ori_pc    (jmp_ori_pc),
      .i_jmp_next_pc   (jmp_next_pc),
      .o_commit_valid  (o_commit_valid),
      .o_commit_tag    (o_commit_tag),
      .o_commit_dest   (o_commit_dest),
      .o_commit_value  (o_commit_value),
      .o_redirect_valid(o_redirect_valid),
      .o_redirect_pc   (o_redirect_pc),
      .o_count         (o_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- model: program-ordered queue of live entries ----------------
   typedef struct {
      int          tag;
      int          dest;
      bit          is_jump;
      bit          done;
      bit          mis;
      logic [31:0] value;
      logic [31:0] npc;
   } ent_t;

   typedef struct {
      int          cyc;
      int          tag;
      logic [31:0] value;
      bit          redirect;
      logic [31:0] rpc;
   } log_t;

   ent_t        rob[$];
   log_t        clog[$];
   int          m_tail;
   bit          e_cv, e_rv, e_fresh;
   int          e_tag, e_dest;
   logic [31:0] e_val, e_rpc;
   int          checks, failures, cyc;
   bit          chk_en;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int find(input int tag);
      for (int i = 0; i < rob.size(); i++) if (rob[i].tag == tag) return i;
      return -1;
   endfunction

   task automatic wb(input int tag, input logic [31:0] val, input logic [31:0] npc,
                     input bit is_jmp);
      int   i;
      ent_t t;
      if (tag == 15 || tag >= ENTRIES) return;
      i = find(tag);
      if (i < 0) return;
      t       = rob[i];
      t.done  = 1'b1;
      t.value = val;
      t.npc   = npc;
      t.mis   = is_jmp && (npc != val);
      rob[i]  = t;
   endtask

   // Later writes overwrite earlier ones, giving jmp > alu > fwd on a shared tag.
   task automatic apply_wbs();
      wb(int'(fwd_target), fwd_result, 32'h0, 1'b0);
      wb(int'(alu_target), alu_result, 32'h0, 1'b0);
      wb(int'(jmp_target), jmp_ori_pc + 32'd4, jmp_next_pc, 1'b1);
   endtask

   task automatic model_step();
      bit   ready, commit;
      ent_t h, n;
      ready = (rob.size() < ENTRIES) && !e_rv;
      if (!rst) begin
         rob.delete();
         m_tail = 0; e_cv = 0; e_rv = 0; e_fresh = 1;
         e_tag = 15; e_dest = 0; e_val = '0; e_rpc = '0;
         return;
      end
      commit = 0;
`ifdef ROB_BYPASS_EN
      apply_wbs();
      if (rob.size() > 0 && rob[0].done) begin commit = 1; h = rob[0]; end
`else
      if (rob.size() > 0 && rob[0].done) begin commit = 1; h = rob[0]; end
      apply_wbs();
`endif
      e_cv = commit;
      e_rv = 0;
      if (commit) begin
         void'(rob.pop_front());
         e_tag = h.tag; e_dest = h.dest; e_val = h.value; e_fresh = 0;
         if (h.is_jump && h.mis) begin e_rv = 1; e_rpc = h.npc; end
      end
      if (e_rv) begin
         rob.delete();
         m_tail = 0;
      end else if (alloc_valid && ready) begin
         n.tag = m_tail; n.dest = int'(alloc_dest); n.is_jump = alloc_is_jump;
         n.done = 0; n.mis = 0; n.value = '0; n.npc = '0;
         rob.push_back(n);
         m_tail = (m_tail + 1) % ENTRIES;
      end
   endtask

   // ---------------- per-cycle compare process ----------------
   always @(negedge clk) begin
      if (chk_en) begin
         check("count", o_count, rob.size());
         check("alloc_ready", o_alloc_ready, (rob.size() < ENTRIES) && !e_rv);
         check("alloc_tag", o_alloc_tag, m_tail);
         check("commit_valid", o_commit_valid, e_cv);
         check("redirect_valid", o_redirect_valid, e_rv);
         if (e_cv || e_fresh) begin
            check("commit_tag", o_commit_tag, e_tag);
            check("commit_dest", o_commit_dest, e_dest);
            check("commit_value", o_commit_value, e_val);
         end
         if (e_rv || e_fresh) check("redirect_pc", o_redirect_pc, e_rpc);
         if (o_commit_valid === 1'b1)
            clog.push_back('{cyc, int'(o_commit_tag), o_commit_value, o_redirect_valid,
                             o_redirect_pc});
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic idle();
      alloc_valid = 0; alloc_dest = '0; alloc_is_jump = 0;
      alu_target = 4'hF; alu_result = '0;
      fwd_target = 4'hF; fwd_result = '0;
      jmp_target = 4'hF; jmp_ori_pc = '0; jmp_next_pc = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      model_step();
      cyc++;
      @(negedge clk);
      #1;
   endtask

   task automatic do_reset();
      idle();
      rst = 0;
      tick();
      chk_en = 1;
      tick();
      rst = 1;
   endtask

   task automatic alloc(input int dest, input bit j);
      alloc_valid = 1; alloc_dest = 5'(dest); alloc_is_jump = j;
      tick();
      alloc_valid = 0; alloc_is_jump = 0;
   endtask

   function automatic logic [3:0] pick_tag(input bit want_jump);
      int c[$];
      foreach (rob[i]) if (rob[i].is_jump == want_jump) c.push_back(rob[i].tag);
      if (c.size() == 0) return 4'hF;
      return 4'(c[$urandom_range(0, c.size() - 1)]);
   endfunction

   function automatic logic [3:0] garbage_tag();
      int t;
      t = $urandom_range(0, 15);
      if (t < ENTRIES && find(t) >= 0) t = 15;
      return 4'(t);
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int wb_cyc;
      int r;
      checks = 0; failures = 0; cyc = 0; chk_en = 0;
      rst = 0;
      idle();

      // Reset values
      do_reset();
      check("rst_count", o_count, 0);
      check("rst_commit_valid", o_commit_valid, 0);
      check("rst_commit_tag", o_commit_tag, 4'hF);
      check("rst_commit_value", o_commit_value, 0);
      check("rst_redirect_valid", o_redirect_valid, 0);
      check("rst_alloc_ready", o_alloc_ready, 1);

      // In-order completion
      for (int i = 0; i < 3; i++) begin
         check("t1_alloc_tag", o_alloc_tag, i);
         alloc(i + 1, 0);
      end
      clog.delete();
      alu_target = 0; alu_result = 32'h11; tick();
      wb_cyc = cyc;
      alu_target = 1; alu_result = 32'h22; tick();
      alu_target = 2; alu_result = 32'h33; tick();
      idle();
      repeat (4) tick();
      check("t1_ncommits", clog.size(), 3);
      if (clog.size() == 3) begin
         check("t1_tag0", clog[0].tag, 0);
         check("t1_val0", clog[0].value, 32'h11);
         check("t1_tag1", clog[1].tag, 1);
         check("t1_val1", clog[1].value, 32'h22);
         check("t1_tag2", clog[2].tag, 2);
         check("t1_val2", clog[2].value, 32'h33);
         check("t1_consecutive", clog[2].cyc - clog[0].cyc, 2);
         check("t1_latency", clog[0].cyc - wb_cyc, LAT - 1);
      end

      // Out-of-order completion
      do_reset();
      alloc(1, 0); alloc(2, 0);
      clog.delete();
      fwd_target = 1; fwd_result = 32'hB; tick();
      idle();
      repeat (3) tick();
      check("t2_no_early_commit", clog.size(), 0);
      alu_target = 0; alu_result = 32'hA; tick();
      idle();
      repeat (4) tick();
      check("t2_ncommits", clog.size(), 2);
      if (clog.size() == 2) begin
         check("t2_first", {clog[0].tag, clog[0].value}, {32'd0, 32'hA});
         check("t2_second", {clog[1].tag, clog[1].value}, {32'd1, 32'hB});
         check("t2_consecutive", clog[1].cyc - clog[0].cyc, 1);
      end

      // Full table and wrap-around
      do_reset();
      for (int i = 0; i < ENTRIES; i++) alloc(i, 0);
      check("t3_full_count", o_count, 8);
      check("t3_full_ready", o_alloc_ready, 0);
      alloc(9, 0);
      check("t3_blocked_count", o_count, 8);
      check("t3_blocked_tag", o_alloc_tag, 0);
      idle();
      alu_target = 0; alu_result = 32'h50; tick();
      idle();
      for (int k = 0; k < 6 && o_count != 4'd7; k++) tick();
      check("t3_count7", o_count, 7);
      check("t3_wrap_tag", o_alloc_tag, 0);
      check("t3_ready", o_alloc_ready, 1);
      alu_target = 1; alu_result = 32'h51;
      if (LAT == 1) begin alloc_valid = 1; alloc_dest = 5'd9; end
      tick();
      if (LAT == 2) begin
         idle();
         alloc_valid = 1; alloc_dest = 5'd9;
         tick();
      end
      idle();
      check("t3_count_stays", o_count, 7);
      check("t3_next_tag", o_alloc_tag, 1);
      check("t3_commit_tag", o_commit_tag, 1);
      check("t3_commit_value", o_commit_value, 32'h51);
      repeat (2) tick();

      // Collisions: alu beats fwd, jmp beats alu
      do_reset();
      alloc(1, 0); alloc(2, 0); alloc(3, 0); alloc(4, 1);
      clog.delete();
      alu_target = 0; alu_result = 32'h70; fwd_target = 0; fwd_result = 32'h71; tick();
      idle(); alu_target = 1; alu_result = 32'h72; tick();
      idle(); fwd_target = 2; fwd_result = 32'h73; tick();
      idle();
      alu_target = 3; alu_result = 32'hDEAD;
      jmp_target = 3; jmp_ori_pc = 32'h100; jmp_next_pc = 32'h104; tick();
      idle();
      repeat (5) tick();
      check("t4_ncommits", clog.size(), 4);
      if (clog.size() == 4) begin
         check("t4_alu_over_fwd", clog[0].value, 32'h70);
         check("t4_jmp_tag", clog[3].tag, 3);
         check("t4_jmp_value", clog[3].value, 32'h104);
         check("t4_no_redirect", clog[3].redirect, 0);
      end

      // Mispredict redirect and flush
      do_reset();
      alloc(7, 1); alloc(1, 0); alloc(2, 0); alloc(3, 0);
      clog.delete();
      jmp_target = 0; jmp_ori_pc = 32'h200; jmp_next_pc = 32'h300;
      alloc_valid = 1; alloc_dest = 5'd5;
      tick();
      jmp_target = 4'hF;
      for (int k = 0; k < 6 && o_commit_valid !== 1'b1; k++) tick();
      check("t5_commit_valid", o_commit_valid, 1);
      check("t5_commit_tag", o_commit_tag, 0);
      check("t5_commit_value", o_commit_value, 32'h204);
      check("t5_redirect_valid", o_redirect_valid, 1);
      check("t5_redirect_pc", o_redirect_pc, 32'h300);
      check("t5_flushed_count", o_count, 0);
      check("t5_ready_during_pulse", o_alloc_ready, 0);
      tick();
      idle();
      check("t5_pulse_ends", o_redirect_valid, 0);
      check("t5_count_after", o_count, 0);
      check("t5_tag_after", o_alloc_tag, 0);
      alu_target = 1; alu_result = 32'h1; fwd_target = 2; fwd_result = 32'h2; tick();
      idle(); alu_target = 3; alu_result = 32'h3; tick();
      idle();
      repeat (4) tick();
      check("t5_no_late_commits", clog.size(), 1);

      // Reset mid-stream
      do_reset();
      alloc(1, 0); alloc(2, 0); alloc(3, 0);
      alu_target = 0; alu_result = 32'h90; tick();
      idle();
      rst = 0; alu_target = 1; alu_result = 32'h91; tick();
      rst = 1; idle();
      check("t6_count", o_count, 0);
      check("t6_commit_valid", o_commit_valid, 0);
      check("t6_commit_tag", o_commit_tag, 4'hF);
      repeat (3) tick();
      check("t6_stays_empty", o_count, 0);

      // Randomized traffic
      do_reset();
      for (int n = 0; n < 4000; n++) begin
         idle();
         rst = ($urandom_range(0, 249) != 0);
         if ($urandom_range(0, 9) < 6) begin
            alloc_valid = 1;
            alloc_dest = 5'($urandom);
            alloc_is_jump = ($urandom_range(0, 3) == 0);
         end
         r = $urandom_range(0, 9);
         alu_result = $urandom;
         if (r < 5) alu_target = pick_tag(0);
         else if (r < 7) alu_target = garbage_tag();
         r = $urandom_range(0, 9);
         fwd_result = $urandom;
         if (r < 4) fwd_target = pick_tag(0);
         else if (r < 6) fwd_target = garbage_tag();
         r = $urandom_range(0, 9);
         if (r < 5) begin
            jmp_target = pick_tag(1);
            if ($urandom_range(0, 15) == 0) begin
               jmp_ori_pc = 32'hFFFF_FFFC;
               jmp_next_pc = ($urandom_range(0, 1) == 0) ? 32'h0 : 32'h4;
            end else begin
               jmp_ori_pc = $urandom & 32'hFFFF_FFFC;
               jmp_next_pc = ($urandom_range(0, 9) < 7) ? jmp_ori_pc + 32'd4 : $urandom;
            end
         end else if (r < 6) begin
            jmp_target = garbage_tag();
            jmp_ori_pc = $urandom;
            jmp_next_pc = $urandom;
         end
         tick();
      end
      rst = 1;
      idle();
      repeat (4) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
